// File: rtl/spi_host_pkg.sv
// Shared types and command constants for the SPI host master that feeds the
// guest core's user_io / data_io / OSD configuration slaves.
package spi_host_pkg;

  typedef enum logic [1:0] {
    CS_USERIO = 2'd0,
    CS_DATAIO = 2'd1,
    CS_OSD    = 2'd2,
    CS_DIRECT = 2'd3
  } cs_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_HOLD    = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  localparam logic [7:0] UIO_GET_STATUS = 8'h50;
  localparam logic [7:0] FILE_TX        = 8'h53;
  localparam logic [7:0] FILE_TX_DAT    = 8'h54;
  localparam logic [7:0] FILE_INDEX     = 8'h55;

  // Active-low select vector ordered {ss4, ss3, ss2, conf_data0}.
  function automatic logic [3:0] cs_decode(input logic [1:0] sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/spi_host_master_clk_div.sv
// Loadable down-counter: one-cycle tick every CLKDIV enabled cycles.
module spi_clk_div #(
  parameter int CLKDIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_tick
);

  localparam int            CW     = $clog2(CLKDIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)       r_cnt <= '0;
    else if (i_load) r_cnt <= RELOAD;
    else if (i_en)   r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - 1'b1;
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/spi_host_master.sv
// Byte-oriented SPI mode-0 master (MSB first) with client-controlled framing
// on one of four active-low chip selects.
module spi_host_master
  import spi_host_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cs_sel,
  input  logic       cs_active,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       conf_data0,
  output logic       spi_ss2,
  output logic       spi_ss3,
  output logic       spi_ss4
);

  state_e     r_state;
  state_e     w_next;
  logic       w_load;
  logic       w_accept;
  logic       w_ready;
  logic       w_tick;
  logic       w_div_en;

  logic       r_sck;
  logic       r_mosi;
  logic       r_miso_bit;
  logic [6:0] r_sr;
  logic [3:0] r_edge;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic [3:0] r_cs_n;

  assign w_div_en = (r_state == ST_SETUP) || (r_state == ST_SHIFT) ||
                    (r_state == ST_RELEASE);

  spi_clk_div #(.CLKDIV(CLKDIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_en   (w_div_en),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Deselect beats a pending byte in HOLD because ready already follows cs_active.
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_accept = 1'b0;
    w_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cs_active) begin
          w_next = ST_SETUP;
          w_load = 1'b1;
        end
      end
      ST_SETUP: begin
        if (w_tick) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        w_ready = cs_active;
        if (!cs_active) begin
          w_next = ST_RELEASE;
          w_load = 1'b1;
        end else if (tx_valid) begin
          w_accept = 1'b1;
          w_next   = ST_SHIFT;
          w_load   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_tick && (r_edge == 4'd15)) w_next = ST_HOLD;
      end
      ST_RELEASE: begin
        if (w_tick) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Chip selects are registered so they never glitch; cs_sel is taken only on frame open.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_edge     <= 4'd0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_cs_n     <= 4'hF;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_next == ST_IDLE)      r_cs_n <= 4'hF;
      else if (r_state == ST_IDLE) r_cs_n <= cs_decode(cs_sel);
      if (w_accept) begin
        r_mosi <= tx_data[7];
      end else if ((r_state == ST_SHIFT) && w_tick) begin
        r_sck  <= ~r_sck;
        r_edge <= r_edge + 1'b1;
        if (r_sck) begin
          if (r_edge == 4'd15) begin
            r_rx_data  <= {r_sr, r_miso_bit};
            r_rx_valid <= 1'b1;
          end else begin
            r_mosi <= r_sr[6];
          end
        end
      end
    end
  end

  // r_sr holds the unsent tx bits ahead of the received bits shifting in behind them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sr <= tx_data[6:0];
    end else if ((r_state == ST_SHIFT) && w_tick) begin
      if (!r_sck) r_miso_bit <= spi_miso;
      else        r_sr       <= {r_sr[5:0], r_miso_bit};
    end
  end

  assign tx_ready   = w_ready;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign busy       = (r_state != ST_IDLE);
  assign spi_sck    = r_sck;
  assign spi_mosi   = r_mosi;
  assign conf_data0 = r_cs_n[0];
  assign spi_ss2    = r_cs_n[1];
  assign spi_ss3    = r_cs_n[2];
  assign spi_ss4    = r_cs_n[3];

endmodule

// File: tb/tb_spi_host_master.sv
// Self-checking bench for spi_host_master: vector table plus hand sequences,
// with a scoreboard queue of expected receive bytes.
module tb_spi_host_master;
  import spi_host_pkg::*;

  localparam int C = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  // CLKDIV=2 instance
  logic       reset, cs_active, tx_valid, tx_ready, rx_valid, busy;
  logic       sck, mosi, miso, conf, ss2, ss3, ss4;
  logic [1:0] cs_sel;
  logic [7:0] tx_data, rx_data;
  logic       sl_mode, sl_bit;
  logic [3:0] cs_vec;
  assign miso   = sl_mode ? sl_bit : mosi;
  assign cs_vec = {ss4, ss3, ss2, conf};

  spi_host_master #(.CLKDIV(C)) dut (
    .clk(clk), .reset(reset), .cs_sel(cs_sel), .cs_active(cs_active),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .spi_sck(sck), .spi_mosi(mosi), .spi_miso(miso),
    .conf_data0(conf), .spi_ss2(ss2), .spi_ss3(ss3), .spi_ss4(ss4)
  );

  // CLKDIV=1 instance, MISO looped back to MOSI
  logic       reset1, cs_active1, tx_valid1, tx_ready1, rx_valid1, busy1;
  logic       sck1, mosi1, conf1, ss2_1, ss3_1, ss4_1;
  logic [1:0] cs_sel1;
  logic [7:0] tx_data1, rx_data1;
  logic [3:0] cs_vec1;
  assign cs_vec1 = {ss4_1, ss3_1, ss2_1, conf1};

  spi_host_master #(.CLKDIV(1)) dut1 (
    .clk(clk), .reset(reset1), .cs_sel(cs_sel1), .cs_active(cs_active1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
    .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(mosi1),
    .conf_data0(conf1), .spi_ss2(ss2_1), .spi_ss3(ss3_1), .spi_ss4(ss4_1)
  );

  typedef struct {
    logic [1:0] sel;
    logic [7:0] tx;
    logic       slave;
    logic [7:0] sl;
    logic [7:0] exp_rx;
    logic [3:0] exp_cs;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_chk(input string name, input logic [7:0] act);
    if (sb.size() > 0) chk(name, act, sb.pop_front());
    else               chk({name, "_sb_empty"}, sb.size(), 1);
  endtask

  task automatic open_frame(input logic [1:0] sel, input logic [3:0] exp_cs);
    int n, t;
    cs_sel = sel; cs_active = 1'b1; n = cyc;
    @(negedge clk);
    chk("cs_low_next_cycle", cs_vec, exp_cs);
    chk("busy_in_frame", busy, 1);
    t = 0;
    while (!tx_ready && t < 20) begin @(negedge clk); t++; end
    chk("ready_latency", cyc - n, C + 1);
  endtask

  task automatic close_frame();
    int n, t, rises, rdy, rxv;
    logic psck;
    cs_active = 1'b0;
    #1;
    chk("ready_low_on_close", tx_ready, 0);
    n = cyc; t = 0; rises = 0; rdy = 0; rxv = 0; psck = sck;
    do begin
      @(negedge clk); t++;
      if (sck && !psck) rises++;
      psck = sck;
      if (tx_ready) rdy++;
      if (rx_valid) rxv++;
    end while (cs_vec != 4'hF && t < 20);
    chk("release_latency", cyc - n, C + 1);
    chk("busy_after_release", busy, 0);
    chk("no_sck_in_release", rises, 0);
    chk("no_ready_in_release", rdy, 0);
    chk("no_extra_rx_valid", rxv, 0);
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] sl, input logic [7:0] exp_rx,
                      input logic [3:0] exp_cs, input bit hold, input int drop_at,
                      input logic [1:0] new_sel, output int acc);
    int t, nr, first, last, rxc, csbad;
    logic [7:0] mcap, slsh;
    logic got, psck;
    slsh = sl; sl_bit = slsh[7];
    tx_data = tx; tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 100) begin @(negedge clk); t++; end
    chk("accept_ready", tx_ready, 1);
    acc = cyc + 1;
    sb.push_back(exp_rx);
    @(posedge clk); #1;
    if (!hold) tx_valid = 1'b0;
    nr = 0; first = 0; last = 0; rxc = 0; csbad = 0; mcap = 8'h00; got = 1'b0; psck = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (k == drop_at) begin cs_active = 1'b0; cs_sel = new_sel; end
      if (cs_vec != exp_cs) csbad++;
      if (sck && !psck) begin
        if (nr == 0) first = cyc;
        last = cyc;
        nr++;
        mcap = {mcap[6:0], mosi};
        slsh = {slsh[6:0], 1'b0};
        sl_bit = slsh[7];
      end
      psck = sck;
      if (rx_valid) begin got = 1'b1; rxc = cyc; end
    end
    chk("rx_valid_seen", got, 1);
    chk("byte_latency", rxc - acc, 16 * C);
    chk("first_rise_delay", first - acc, C);
    chk("sck_period_span", last - first, 14 * C);
    chk("sck_pulses", nr, 8);
    chk("mosi_sampled", mcap, tx);
    chk("cs_stable_in_byte", csbad, 0);
    chk("sck_low_at_rx", sck, 0);
    pop_chk("rx_data", rx_data);
  endtask

  task automatic xfer1(input logic [7:0] tx);
    int acc, t;
    logic got;
    t = 0;
    while (!tx_ready1 && t < 50) begin @(negedge clk); t++; end
    chk("d1_ready", tx_ready1, 1);
    tx_data1 = tx; tx_valid1 = 1'b1; acc = cyc + 1;
    sb.push_back(tx);
    @(posedge clk); #1;
    tx_valid1 = 1'b0;
    got = 1'b0; t = 0;
    while (!got && t < 50) begin @(negedge clk); t++; if (rx_valid1) got = 1'b1; end
    chk("d1_latency", cyc - acc, 16);
    pop_chk("d1_rx_data", rx_data1);
  endtask

  initial begin
    int a1, a2, a3, t;
    vecs[0] = '{CS_DATAIO, 8'hA5,       1'b0, 8'h00, 8'hA5, 4'b1101};
    vecs[1] = '{CS_USERIO, FILE_TX,     1'b1, 8'h3C, 8'h3C, 4'b1110};
    vecs[2] = '{CS_OSD,    8'h00,       1'b1, 8'hFF, 8'hFF, 4'b1011};
    vecs[3] = '{CS_DIRECT, 8'h80,       1'b1, 8'h01, 8'h01, 4'b0111};
    vecs[4] = '{CS_USERIO, FILE_INDEX,  1'b0, 8'h00, 8'h55, 4'b1110};
    vecs[5] = '{CS_DATAIO, FILE_TX_DAT, 1'b1, 8'hC6, 8'hC6, 4'b1101};

    reset = 1'b1; cs_active = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; cs_sel = 2'd0;
    sl_mode = 1'b0; sl_bit = 1'b0;
    reset1 = 1'b1; cs_active1 = 1'b0; tx_valid1 = 1'b0; tx_data1 = 8'h00; cs_sel1 = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset_cs", cs_vec, 4'hF);
    chk("reset_sck", sck, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", tx_ready, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 8'h00);
    reset = 1'b0; reset1 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      sl_mode = vecs[i].slave;
      open_frame(vecs[i].sel, vecs[i].exp_cs);
      xfer(vecs[i].tx, vecs[i].sl, vecs[i].exp_rx, vecs[i].exp_cs, 1'b0, -1, 2'd0, a1);
      close_frame();
    end
    sl_mode = 1'b0;

    // Burst with tx_valid held across bytes
    open_frame(CS_DATAIO, 4'b1101);
    xfer(8'h01, 8'h00, 8'h01, 4'b1101, 1'b1, -1, 2'd0, a1);
    xfer(8'h02, 8'h00, 8'h02, 4'b1101, 1'b1, -1, 2'd0, a2);
    chk("burst_ready_with_rx", tx_ready, 1);
    xfer(8'h03, 8'h00, 8'h03, 4'b1101, 1'b1, -1, 2'd0, a3);
    tx_valid = 1'b0;
    chk("burst_gap_1", a2 - a1, 16 * C + 1);
    chk("burst_gap_2", a3 - a2, 16 * C + 1);
    close_frame();

    // Close race: deselect together with a byte offer in HOLD
    open_frame(CS_OSD, 4'b1011);
    tx_data = 8'hEE; tx_valid = 1'b1;
    close_frame();
    tx_valid = 1'b0;
    chk("race_no_rx", rx_valid, 0);

    // Mid-byte deselect with cs_sel change
    open_frame(CS_DIRECT, 4'b0111);
    xfer(8'h96, 8'h00, 8'h96, 4'b0111, 1'b0, 10, CS_USERIO, a1);
    close_frame();
    open_frame(cs_sel, 4'b1110);
    xfer(8'h69, 8'h00, 8'h69, 4'b1110, 1'b0, -1, 2'd0, a1);
    close_frame();

    // CLKDIV=1 instance: reset mid-SHIFT, then a clean 0xFF transfer
    cs_sel1 = CS_OSD; cs_active1 = 1'b1;
    xfer1(8'hC3);
    t = 0;
    while (!tx_ready1 && t < 20) begin @(negedge clk); t++; end
    tx_data1 = 8'h81; tx_valid1 = 1'b1;
    @(posedge clk); #1;
    tx_valid1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("d1_busy_mid_shift", busy1, 1);
    reset1 = 1'b1; cs_active1 = 1'b0;
    @(negedge clk);
    chk("d1_reset_cs", cs_vec1, 4'hF);
    chk("d1_reset_sck", sck1, 0);
    chk("d1_reset_mosi", mosi1, 0);
    chk("d1_reset_rx_valid", rx_valid1, 0);
    chk("d1_reset_rx_data", rx_data1, 8'h00);
    chk("d1_reset_busy", busy1, 0);
    chk("d1_reset_ready", tx_ready1, 0);
    reset1 = 1'b0;
    @(negedge clk);
    cs_sel1 = CS_DIRECT; cs_active1 = 1'b1;
    xfer1(8'hFF);
    chk("d1_cs_direct", cs_vec1, 4'b0111);
    cs_active1 = 1'b0;
    t = 0;
    while (busy1 && t < 20) begin @(negedge clk); t++; end
    chk("d1_idle_after_close", {busy1, cs_vec1}, 5'h0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
